// File: rtl/activation_pkg.sv
// Shared types and defaults for the activation pipeline.
// Provides the mode enum, default widths and the rounding constant.
package activation_pkg;

    typedef enum logic [1:0] {
        MODE_RELU        = 2'd0,
        MODE_LEAKY_SHIFT = 2'd1,
        MODE_PRELU       = 2'd2,
        MODE_CLIP        = 2'd3
    } mode_e;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_FRAC        = 5;
    localparam int DEF_ALPHA_WIDTH = 8;
    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_ALPHA_RESET = 'h20;

    // Half an LSB of a value with frac_bits fractional bits.
    function automatic int round_const(input int frac_bits);
        return 1 << (frac_bits - 1);
    endfunction

endpackage

// File: rtl/activation_if.sv
// Stream and config bundle of the activation pipeline.
// slave: the pipe (takes cfg_*, in_*, out_ready; drives in_ready, out_*).
// master: the mirror view for whoever drives and consumes the stream.
interface activation_if #(
    parameter int WIDTH       = activation_pkg::DEF_WIDTH,
    parameter int ALPHA_WIDTH = activation_pkg::DEF_ALPHA_WIDTH,
    parameter int CH_W        = 2
);
    logic                       cfg_we;
    logic [CH_W-1:0]            cfg_ch;
    logic [ALPHA_WIDTH-1:0]     cfg_alpha;
    logic                       in_valid;
    logic                       in_ready;
    logic [CH_W-1:0]            in_ch;
    activation_pkg::mode_e      in_mode;
    logic signed [WIDTH-1:0]    x_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [CH_W-1:0]            out_ch;
    logic signed [WIDTH-1:0]    y_out;
    logic                       sat_flag;

    modport slave (
        input  cfg_we, cfg_ch, cfg_alpha,
        input  in_valid, in_ch, in_mode, x_in,
        input  out_ready,
        output in_ready,
        output out_valid, out_ch, y_out, sat_flag
    );

    modport master (
        output cfg_we, cfg_ch, cfg_alpha,
        output in_valid, in_ch, in_mode, x_in,
        output out_ready,
        input  in_ready,
        input  out_valid, out_ch, y_out, sat_flag
    );

endinterface

// File: rtl/activation_alpha_bank.sv
// Per-channel alpha register file: one write port, one async read port.
// Ports: clk, reset, we/wr_ch/wr_data (write), rd_ch -> rd_data (read).
module activation_alpha_bank #(
    parameter int                     CHANNELS    = 4,
    parameter int                     ALPHA_WIDTH = 8,
    parameter int                     CH_W        = 2,
    parameter logic [ALPHA_WIDTH-1:0] ALPHA_RESET = 8'h20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [ALPHA_WIDTH-1:0] wr_data,
    input  logic [CH_W-1:0]        rd_ch,
    output logic [ALPHA_WIDTH-1:0] rd_data
);

    logic [ALPHA_WIDTH-1:0] alpha_q [CHANNELS];
    logic [ALPHA_WIDTH-1:0] alpha_d [CHANNELS];

    always_comb begin
        alpha_d = alpha_q;
        if (we) begin
            alpha_d[wr_ch] = wr_data;
        end
    end

    // Read sees the pre-edge value, so a same-cycle write is not forwarded.
    assign rd_data = alpha_q[rd_ch];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                alpha_q[i] <= ALPHA_RESET;
            end
        end else begin
            alpha_q <= alpha_d;
        end
    end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage multi-mode activation unit with per-channel alpha.
// Ports: clk, reset, bus (slave: cfg write, input stream, output stream).
module activation_pipe
    import activation_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int FRAC        = DEF_FRAC,
    parameter int ALPHA_WIDTH = DEF_ALPHA_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int CH_W        = $clog2(CHANNELS),
    parameter logic [ALPHA_WIDTH-1:0] ALPHA_RESET =
        ALPHA_WIDTH'(DEF_ALPHA_RESET)
) (
    input logic        clk,
    input logic        reset,
    activation_if.slave bus
);

    localparam int PW   = WIDTH + ALPHA_WIDTH + 1;
    localparam int YMAX = 2 ** (WIDTH - 1) - 1;
    localparam logic signed [PW-1:0] RND =
        PW'(round_const(ALPHA_WIDTH));
    localparam logic [ALPHA_WIDTH-1:0] SHMAX =
        ALPHA_WIDTH'(WIDTH - 1);

    if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_chk
        $error("FRAC must lie in [0, WIDTH-1]");
    end

    typedef struct packed {
        logic signed [WIDTH-1:0] x;
        logic [CH_W-1:0]         ch;
        mode_e                   mode;
        logic [ALPHA_WIDTH-1:0]  alpha;
    } s1_t;

    typedef struct packed {
        logic signed [WIDTH-1:0] y;
        logic [CH_W-1:0]         ch;
        logic                    sat;
    } s2_t;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    s2_t  res;
    logic adv1, adv2;

    logic [ALPHA_WIDTH-1:0]  rd_alpha;
    logic signed [WIDTH-1:0] x1;
    logic [ALPHA_WIDTH-1:0]  shamt;
    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] clip_t;

    activation_alpha_bank #(
        .CHANNELS    (CHANNELS),
        .ALPHA_WIDTH (ALPHA_WIDTH),
        .CH_W        (CH_W),
        .ALPHA_RESET (ALPHA_RESET)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.cfg_we),
        .wr_ch   (bus.cfg_ch),
        .wr_data (bus.cfg_alpha),
        .rd_ch   (bus.in_ch),
        .rd_data (rd_alpha)
    );

    assign adv2 = ~s2_valid_q | bus.out_ready;
    assign adv1 = ~s1_valid_q | adv2;
    assign x1   = s1_q.x;

    // Result of the beat held in S1, registered into S2.
    always_comb begin
        res     = '0;
        res.ch  = s1_q.ch;
        res.y   = x1;
        res.sat = 1'b0;
        shamt   = (s1_q.alpha > SHMAX) ? SHMAX : s1_q.alpha;
        prod    = $signed({{(PW-WIDTH){x1[WIDTH-1]}}, x1})
                * $signed({{(PW-ALPHA_WIDTH){1'b0}}, s1_q.alpha});
        // Clip level is alpha read as raw output LSBs, capped at +max.
        clip_t  = (int'(s1_q.alpha) > YMAX) ? WIDTH'(YMAX)
                                            : WIDTH'(s1_q.alpha);
        if (x1[WIDTH-1]) begin
            unique case (s1_q.mode)
                MODE_RELU:        res.y = '0;
                MODE_LEAKY_SHIFT: res.y = x1 >>> shamt;
                MODE_PRELU:
                    res.y = WIDTH'((prod + RND) >>> ALPHA_WIDTH);
                MODE_CLIP:        res.y = '0;
            endcase
        end else if (s1_q.mode == MODE_CLIP && x1 > clip_t) begin
            res.y   = clip_t;
            res.sat = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.x     = bus.x_in;
                s1_d.ch    = bus.in_ch;
                s1_d.mode  = bus.in_mode;
                s1_d.alpha = rd_alpha;
            end
        end
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = res;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.y_out     = s2_q.y;
    assign bus.out_ch    = s2_q.ch;
    assign bus.sat_flag  = s2_q.sat;

endmodule
